// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing FSM: Moore decode of datapath strobes per state,
// memory states stretched until MemReady, with a watchdog on stalled memory
// and recovery from illegal opcodes.
module multicycle_control #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       PCWriteCondEQ,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic       JalLink,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic       Timeout,
  output logic [3:0] StateOut
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WB    = 4'd4;
  localparam logic [3:0] MEM_WRITE = 4'd5;
  localparam logic [3:0] EXEC_R    = 4'd6;
  localparam logic [3:0] R_WB      = 4'd7;
  localparam logic [3:0] EXEC_I    = 4'd8;
  localparam logic [3:0] I_WB      = 4'd9;
  localparam logic [3:0] BRANCH    = 4'd10;
  localparam logic [3:0] JUMP      = 4'd11;
  localparam logic [3:0] JAL       = 4'd12;
  localparam logic [3:0] JR        = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;

  localparam int CNT_W = (WAIT_LIMIT > 15) ? $clog2(WAIT_LIMIT + 1) : 4;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  logic [3:0]       state;
  logic [3:0]       nextState;
  logic [CNT_W-1:0] waitCnt;
  logic             memState;
  logic             timeoutRaw;
  logic             pcWriteRaw;
  logic             irWriteRaw;
  logic             regWriteRaw;
  logic             memWriteRaw;
  logic             condEqRaw;
  logic             condNeRaw;
  logic             illegalRaw;

  // Zero is qualified in the datapath; the port stays for interface compatibility.
  logic unusedZero;
  assign unusedZero = Zero;

  // I-type ALU operation, shared by EXEC_I and I_WB so the result stays stable.
  function automatic logic [2:0] immAluOp(input logic [5:0] op);
    case (op)
      OP_ANDI: immAluOp = ALU_AND;
      OP_ORI:  immAluOp = ALU_OR;
      OP_LUI:  immAluOp = ALU_LUI;
      default: immAluOp = ALU_ADD;
    endcase
  endfunction

  assign memState   = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
  assign timeoutRaw = (WAIT_LIMIT != 0) && memState && !MemReady && (waitCnt == LIMIT_M1);

  // Moore output decode and next-state selection for the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    nextState   = state;
    pcWriteRaw  = 1'b0;
    irWriteRaw  = 1'b0;
    regWriteRaw = 1'b0;
    memWriteRaw = 1'b0;
    condEqRaw   = 1'b0;
    condNeRaw   = 1'b0;
    illegalRaw  = 1'b0;
    MemRead     = 1'b0;
    IorD        = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    JalLink     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_ADD;
    PCSource    = 2'b00;
    case (state)
      FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        pcWriteRaw = MemReady;
        irWriteRaw = MemReady;
        if (MemReady) nextState = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (OP)
          OP_RTYPE:                         nextState = (Funct == FUNCT_JR) ? JR : EXEC_R;
          OP_LW, OP_SW:                     nextState = MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nextState = EXEC_I;
          OP_BEQ, OP_BNE:                   nextState = BRANCH;
          OP_J:                             nextState = JUMP;
          OP_JAL:                           nextState = JAL;
          default: begin
            illegalRaw = 1'b1;
            nextState  = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nextState = (OP == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) nextState = MEM_WB;
      end
      MEM_WB: begin
        regWriteRaw = 1'b1;
        MemtoReg    = 1'b1;
        nextState   = FETCH;
      end
      MEM_WRITE: begin
        memWriteRaw = 1'b1;
        IorD        = 1'b1;
        if (MemReady) nextState = FETCH;
      end
      EXEC_R: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALU_FUNCT;
        nextState = R_WB;
      end
      R_WB: begin
        regWriteRaw = 1'b1;
        RegDst      = 1'b1;
        nextState   = FETCH;
      end
      EXEC_I: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = immAluOp(OP);
        nextState = I_WB;
      end
      I_WB: begin
        regWriteRaw = 1'b1;
        ALUOp       = immAluOp(OP);
        nextState   = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALU_SUB;
        PCSource  = 2'b01;
        condEqRaw = (OP == OP_BEQ);
        condNeRaw = (OP == OP_BNE);
        nextState = FETCH;
      end
      JUMP: begin
        pcWriteRaw = 1'b1;
        PCSource   = 2'b10;
        nextState  = FETCH;
      end
      JAL: begin
        pcWriteRaw  = 1'b1;
        PCSource    = 2'b10;
        regWriteRaw = 1'b1;
        JalLink     = 1'b1;
        nextState   = FETCH;
      end
      JR: begin
        pcWriteRaw = 1'b1;
        PCSource   = 2'b11;
        nextState  = FETCH;
      end
      default: nextState = FETCH;
    endcase
    if (timeoutRaw) nextState = FETCH;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= FETCH;
    else        state <= nextState;
  end

  // Memory wait counter: counts stalled cycles, clears on state change or timeout.
  always_ff @(posedge clk) begin
    if (!reset)                                  waitCnt <= '0;
    else if ((nextState != state) || timeoutRaw) waitCnt <= '0;
    else if (memState && !MemReady && (waitCnt != '1))
      waitCnt <= waitCnt + 1'b1;
  end

  // Write strobes and error pulses are suppressed for as long as reset is held.
  assign PCWrite       = reset & pcWriteRaw;
  assign IRWrite       = reset & irWriteRaw;
  assign RegWrite      = reset & regWriteRaw;
  assign MemWrite      = reset & memWriteRaw;
  assign PCWriteCondEQ = reset & condEqRaw;
  assign PCWriteCondNE = reset & condNeRaw;
  assign Illegal       = reset & illegalRaw;
  assign Timeout       = reset & timeoutRaw;
  assign StateOut      = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected states are
// queued as stimulus is planned, then popped and compared against the DUT.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP, Funct;
  logic       Zero, MemReady;
  logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite;
  logic       PCWriteCondEQ, PCWriteCondNE;
  logic       IorD, MemtoReg, RegDst, ALUSrcA, JalLink;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic       Illegal, Timeout;
  logic [3:0] StateOut;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic [3:0] st;
    logic       mr;
    logic       to;
    logic [5:0] op;
    logic [5:0] fn;
  } item_t;

  item_t sb[$];

  multicycle_control #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .PCWriteCondEQ(PCWriteCondEQ), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .JalLink(JalLink), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .Illegal(Illegal), .Timeout(Timeout), .StateOut(StateOut)
  );

  always #5 clk = ~clk;

  logic [24:0] obs;
  assign obs = {StateOut, PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
                PCWriteCondEQ, PCWriteCondNE, IorD, MemtoReg, RegDst, ALUSrcA,
                JalLink, ALUSrcB, ALUOp, PCSource, Illegal, Timeout};

  // Reference decode of every output for a given state, taken from the state table.
  function automatic logic [24:0] model(input logic [3:0] st, input logic [5:0] op,
                                        input logic mr, input logic to);
    logic pcW, irW, regW, memR, memW, ceq, cne, iord, m2r, rdst, asa, jal, ill;
    logic [1:0] asb, psrc;
    logic [2:0] aop, immOp;
    {pcW, irW, regW, memR, memW, ceq, cne, iord, m2r, rdst, asa, jal, ill} = '0;
    asb = 2'b00; psrc = 2'b00; aop = 3'b000;
    immOp = (op == 6'h0C) ? 3'b100 : (op == 6'h0D) ? 3'b011 :
            (op == 6'h0F) ? 3'b101 : 3'b000;
    case (st)
      4'd0:  begin memR = 1; asb = 2'b01; pcW = mr; irW = mr; end
      4'd1:  begin
        asb = 2'b11;
        ill = !(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                           6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B});
      end
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin memR = 1; iord = 1; end
      4'd4:  begin regW = 1; m2r = 1; end
      4'd5:  begin memW = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 3'b010; end
      4'd7:  begin regW = 1; rdst = 1; end
      4'd8:  begin asa = 1; asb = 2'b10; aop = immOp; end
      4'd9:  begin regW = 1; aop = immOp; end
      4'd10: begin asa = 1; aop = 3'b001; psrc = 2'b01; ceq = (op == 6'h04); cne = (op == 6'h05); end
      4'd11: begin pcW = 1; psrc = 2'b10; end
      4'd12: begin pcW = 1; psrc = 2'b10; regW = 1; jal = 1; end
      4'd13: begin pcW = 1; psrc = 2'b11; end
      default: ;
    endcase
    return {st, pcW, irW, regW, memR, memW, ceq, cne, iord, m2r, rdst, asa,
            jal, asb, aop, psrc, ill, to};
  endfunction

  task automatic pushStep(input logic [3:0] st, input logic mr, input logic to,
                          input logic [5:0] op, input logic [5:0] fn);
    item_t it;
    it.st = st; it.mr = mr; it.to = to; it.op = op; it.fn = fn;
    sb.push_back(it);
  endtask

  // FETCH with an immediate handshake, then DECODE; MemReady is don't-care there.
  task automatic pushFetchDecode(input logic [5:0] op, input logic [5:0] fn);
    pushStep(4'd0, 1'b1, 1'b0, op, fn);
    pushStep(4'd1, 1'($urandom_range(0, 1)), 1'b0, op, fn);
  endtask

  // Drive each queued cycle and compare the DUT against the model at the falling edge.
  task automatic drainScoreboard();
    item_t it;
    logic [24:0] expV;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      OP = it.op; Funct = it.fn; MemReady = it.mr; Zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      expV = model(it.st, it.op, it.mr, it.to);
      testsRun++;
      if (obs !== expV) begin
        failCount++;
        $display("FAIL step st=%0d op=%h mr=%0b: got %h expected %h",
                 it.st, it.op, it.mr, obs, expV);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic checkStrobesLow(input string name, input logic [3:0] expSt);
    @(negedge clk);
    testsRun++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite, PCWriteCondEQ, PCWriteCondNE,
         Illegal, Timeout} !== 8'h00 || StateOut !== expSt) begin
      failCount++;
      $display("FAIL %s: state=%0d strobes=%b expected state=%0d strobes=00000000", name,
               StateOut, {PCWrite, IRWrite, RegWrite, MemWrite, PCWriteCondEQ,
               PCWriteCondNE, Illegal, Timeout}, expSt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    MemReady = 1'b1; OP = 6'h00; Funct = 6'h20;
    // Held in FETCH with MemReady=1: writes must still be masked.
    checkStrobesLow("reset_hold", 4'd0);
    reset = 1'b1;
    @(negedge clk);
    testsRun++;
    if (StateOut !== 4'd0 || PCWrite !== 1'b1 || IRWrite !== 1'b1) begin
      failCount++;
      $display("FAIL reset_release: state=%0d PCWrite=%b IRWrite=%b expected 0 1 1",
               StateOut, PCWrite, IRWrite);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Now in EXEC_R; abandon it with a two-cycle reset.
    reset = 1'b0;
    checkStrobesLow("reset_mid_exec_r", 4'd6);
    checkStrobesLow("reset_fetch", 4'd0);
    reset = 1'b1;
  endtask

  task automatic test_rtype();
    pushFetchDecode(6'h00, 6'h20);
    pushStep(4'd6, 1'b0, 1'b0, 6'h00, 6'h20);
    pushStep(4'd7, 1'b1, 1'b0, 6'h00, 6'h20);
    drainScoreboard();
  endtask

  task automatic test_load_store();
    pushFetchDecode(6'h23, 6'h00);
    pushStep(4'd2, 1'b0, 1'b0, 6'h23, 6'h00);
    for (int i = 0; i < 3; i++) pushStep(4'd3, 1'b0, 1'b0, 6'h23, 6'h00);
    pushStep(4'd3, 1'b1, 1'b0, 6'h23, 6'h00);
    pushStep(4'd4, 1'b0, 1'b0, 6'h23, 6'h00);
    pushFetchDecode(6'h2B, 6'h00);
    pushStep(4'd2, 1'b1, 1'b0, 6'h2B, 6'h00);
    pushStep(4'd5, 1'b1, 1'b0, 6'h2B, 6'h00);
    drainScoreboard();
  endtask

  task automatic test_itype();
    logic [5:0] ops [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0F};
    for (int i = 0; i < 4; i++) begin
      pushFetchDecode(ops[i], 6'h00);
      pushStep(4'd8, 1'b0, 1'b0, ops[i], 6'h00);
      pushStep(4'd9, 1'b1, 1'b0, ops[i], 6'h00);
    end
    drainScoreboard();
  endtask

  task automatic test_control_flow();
    pushFetchDecode(6'h05, 6'h00); pushStep(4'd10, 1'b0, 1'b0, 6'h05, 6'h00);
    pushFetchDecode(6'h04, 6'h00); pushStep(4'd10, 1'b1, 1'b0, 6'h04, 6'h00);
    pushFetchDecode(6'h02, 6'h00); pushStep(4'd11, 1'b0, 1'b0, 6'h02, 6'h00);
    pushFetchDecode(6'h03, 6'h00); pushStep(4'd12, 1'b1, 1'b0, 6'h03, 6'h00);
    pushFetchDecode(6'h00, 6'h08); pushStep(4'd13, 1'b0, 1'b0, 6'h00, 6'h08);
    drainScoreboard();
  endtask

  task automatic test_illegal();
    pushFetchDecode(6'h3F, 6'h00);
    pushFetchDecode(6'h10, 6'h00);
    drainScoreboard();
  endtask

  task automatic test_timeout();
    // Stalled FETCH: Timeout on the 15th cycle, then FETCH restarts.
    for (int i = 0; i < 14; i++) pushStep(4'd0, 1'b0, 1'b0, 6'h00, 6'h20);
    pushStep(4'd0, 1'b0, 1'b1, 6'h00, 6'h20);
    // MemReady on the 15th cycle wins over the limit.
    for (int i = 0; i < 14; i++) pushStep(4'd0, 1'b0, 1'b0, 6'h00, 6'h20);
    pushStep(4'd0, 1'b1, 1'b0, 6'h00, 6'h20);
    pushStep(4'd1, 1'b0, 1'b0, 6'h00, 6'h20);
    pushStep(4'd6, 1'b0, 1'b0, 6'h00, 6'h20);
    pushStep(4'd7, 1'b0, 1'b0, 6'h00, 6'h20);
    // Stalled MEM_READ also times out back to FETCH.
    pushFetchDecode(6'h23, 6'h00);
    pushStep(4'd2, 1'b0, 1'b0, 6'h23, 6'h00);
    for (int i = 0; i < 14; i++) pushStep(4'd3, 1'b0, 1'b0, 6'h23, 6'h00);
    pushStep(4'd3, 1'b0, 1'b1, 6'h23, 6'h00);
    pushStep(4'd0, 1'b1, 1'b0, 6'h00, 6'h20);
    pushStep(4'd1, 1'b1, 1'b0, 6'h00, 6'h20);
    drainScoreboard();
  endtask

  initial begin
    reset = 1'b0; OP = 6'h00; Funct = 6'h20; Zero = 1'b0; MemReady = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_rtype();
    test_load_store();
    test_itype();
    test_control_flow();
    test_illegal();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing FSM for the multi-cycle variant of the MIPS core. It replaces the single-cycle decode: the PC, IR, register file, ALU and a shared instruction/data memory are all reused across cycles. Each cycle it drives the datapath strobes from the current state. It stretches memory states until the memory handshakes, and recovers from illegal opcodes and stalled memory.

## Interface
- WAIT_LIMIT, 15: maximum cycles a memory state waits for MemReady before Timeout; 0 disables the watchdog.
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising edge of clk.
- OP  input  6  Instruction[31:26] from IR.
- Funct  input  6  Instruction[5:0] from IR.
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory completes the current read/write this cycle.
- PCWrite, IRWrite, RegWrite, MemRead, MemWrite  output  1 each  datapath strobes.
- PCWriteCondEQ, PCWriteCondNE  output  1 each  conditional PC write enables; datapath ANDs with Zero / ~Zero.
- IorD, MemtoReg, RegDst, ALUSrcA, JalLink  output  1 each  mux selects; JalLink forces write register 31, write data = PC.
- ALUSrcB  output  2  00 B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- ALUOp  output  3  000 add, 001 sub, 010 funct-decode, 011 or, 100 and, 101 lui.
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],imm26,00}, 11 register A.
- Illegal, Timeout  output  1 each  one-cycle error pulses.
- StateOut  output  4  current state encoding for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, R_WB 7, EXEC_I 8, I_WB 9, BRANCH 10, JUMP 11, JAL 12, JR 13. Encodings 14–15 are unreachable and go to FETCH.
- Outputs are a Moore decode of state. PCWrite and IRWrite in FETCH are the exception: they equal MemReady. Every unlisted output is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSource=00, PCWrite=IRWrite=MemReady. Goes to DECODE on MemReady.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add. Dispatches on OP:
  - 0x00 goes to EXEC_R, or to JR if Funct=0x08.
  - 0x23 and 0x2B go to MEM_ADDR.
  - 0x08, 0x0C, 0x0D, 0x0F go to EXEC_I.
  - 0x04 and 0x05 go to BRANCH.
  - 0x02 goes to JUMP; 0x03 goes to JAL.
  - Any other OP: Illegal=1 and next state FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add. Goes to MEM_READ for 0x23, MEM_WRITE for 0x2B.
- MEM_READ: MemRead=1, IorD=1. Goes to MEM_WB on MemReady.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Goes to FETCH on MemReady.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Goes to R_WB.
- R_WB: RegWrite=1, RegDst=1. Goes to FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. ALUOp is add for 0x08, and for 0x0C, or for 0x0D, lui for 0x0F. Goes to I_WB.
- I_WB: RegWrite=1, RegDst=0, ALUOp held as in EXEC_I. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01. PCWriteCondEQ=1 if OP=0x04; PCWriteCondNE=1 if OP=0x05. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, JalLink=1. Register 31 receives the current PC (already PC+4). Goes to FETCH.
- JR: PCWrite=1, PCSource=11. Goes to FETCH.
- Watchdog (memory states FETCH, MEM_READ, MEM_WRITE):
  - A 4-bit+ wait counter increments each cycle the FSM is in a memory state with MemReady=0.
  - It clears on any state change.
  - If WAIT_LIMIT≠0 and the counter equals WAIT_LIMIT−1 while MemReady=0, then Timeout=1 that cycle and next state is FETCH. No PC or IR write occurs.
  - MemReady=1 in the same cycle as the limit wins: normal completion, no Timeout.

## Timing
- Reset:
  - While reset=0, PCWrite, IRWrite, RegWrite, MemWrite, PCWriteCondEQ/NE, Illegal and Timeout are forced to 0 combinationally.
  - At the edge where reset=0, state becomes FETCH and the counter becomes 0.
  - After release, outputs are the FETCH decode.
  - Reset mid-instruction abandons it with no further writes.
- Latency with MemReady held at 1:
  - R-type and I-type: 4 cycles.
  - lw: 5 cycles; sw: 4 cycles.
  - beq, bne, j, jal, jr: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each MemReady=0 cycle in a memory state adds exactly 1 cycle.
- MemReady is ignored outside memory states.
- A write strobe is high for exactly one cycle per instruction, except the conditional PC write, which is qualified by Zero in the datapath.

## Test plan
- Reset low 2 cycles mid-EXEC_R → StateOut=0. All write strobes are 0 during reset. After release with MemReady=1, PCWrite=IRWrite=1 on the first cycle.
- OP=0x00, Funct=0x20, MemReady=1 → StateOut sequence 0,1,6,7,0. RegWrite=1 with RegDst=1 only in state 7.
- OP=0x23 with MemReady low 3 cycles in MEM_READ → sequence 0,1,2,3,3,3,3,4,0. MemRead high throughout state 3. Timeout stays 0.
- OP=0x05 → sequence 0,1,10,0 with PCWriteCondNE=1, PCSource=01, ALUOp=001 in state 10. OP=0x03 gives PCWrite=RegWrite=JalLink=1 in state 12.
- OP=0x3F → Illegal pulses one cycle in DECODE, next state 0, no strobes asserted. OP=0x00, Funct=0x08 → state 13, PCSource=11.
- WAIT_LIMIT=15, MemReady held 0 in FETCH → Timeout pulses on the 15th cycle and FETCH restarts with PCWrite never asserted. Repeat with MemReady=1 on the 15th cycle → no Timeout, normal DECODE.
